// File: rtl/fpu_scheduler_if.sv
// fpu_scheduler_if: requester-side bus of the FPU scheduler.
//   req_valid/req_ready : per-requester request handshake
//   req_opA/req_opB/req_op : per-requester operands and opcode (slice i = requester i)
//   rsp_valid/rsp_ready : per-requester response handshake
//   rsp_data : result, shared by all requesters
// master = requesters, slave = scheduler.
interface fpu_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0][31:0] req_opA;
    logic [NUM_REQ-1:0][31:0] req_opB;
    logic [NUM_REQ-1:0][1:0]  req_op;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [NUM_REQ-1:0]       rsp_ready;
    logic [31:0]              rsp_data;

    modport master (
        output req_valid, req_opA, req_opB, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_opA, req_opB, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/fpu_scheduler.sv
// fpu_scheduler: shares one fixed-latency FPU among NUM_REQ requesters.
// Round-robin arbitration in IDLE, one-cycle issue pulse, latency count,
// then the captured result is offered on a valid/ready response channel.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   bus (slave)      : requester request/response channel
//   fpu_opA/B, op    : operands/opcode held towards the FPU
//   fpu_start        : one-cycle issue pulse
//   fpu_out          : FPU result (no done signal; latency counted here)
//   busy             : high outside IDLE
//   grant_id         : current or last granted requester
module fpu_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int ADDSUB_LAT = 2,
    parameter int MULDIV_LAT = 64,
    localparam int IDX_W     = $clog2(NUM_REQ),
    localparam int MAX_LAT   = (ADDSUB_LAT > MULDIV_LAT) ? ADDSUB_LAT : MULDIV_LAT,
    localparam int CNT_W     = $clog2(MAX_LAT) + 1
) (
    input  logic             clk,
    input  logic             reset,
    fpu_scheduler_if.slave   bus,
    output logic [31:0]      fpu_opA,
    output logic [31:0]      fpu_opB,
    output logic [1:0]       fpu_op,
    output logic             fpu_start,
    input  logic [31:0]      fpu_out,
    output logic             busy,
    output logic [IDX_W-1:0] grant_id
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [CNT_W-1:0] AS_LOAD = CNT_W'(ADDSUB_LAT - 1);
    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MULDIV_LAT - 1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [31:0]        opa_q, opa_d, opb_q, opb_d, res_q, res_d;
    logic [1:0]         op_q, op_d;

    // Round-robin pick: first valid requester above last_q, wrapping.
    logic               found;
    logic [IDX_W-1:0]   pick;
    logic [IDX_W-1:0]   cand;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(last_q) + i) % NUM_REQ);
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        grant_d       = grant_q;
        last_d        = last_q;
        opa_d         = opa_q;
        opb_d         = opb_q;
        op_d          = op_q;
        res_d         = res_q;
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        fpu_start     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Gated by reset so no requester sees an acceptance that the
                // reset would immediately discard.
                if (found && !reset) begin
                    bus.req_ready[pick] = 1'b1;
                    grant_d = pick;
                    opa_d   = bus.req_opA[pick];
                    opb_d   = bus.req_opB[pick];
                    op_d    = bus.req_op[pick];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                fpu_start = 1'b1;
                cnt_d     = op_q[1] ? MD_LOAD : AS_LOAD;
                state_d   = WAIT;
            end
            WAIT: begin
                // The ISSUE cycle already consumed one latency cycle, so the
                // FPU result is valid when the counter reads 1 (or 0 for LAT=1),
                // i.e. LAT cycles after acceptance.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    res_d   = fpu_out;
                    state_d = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid[grant_q] = 1'b1;
                if (bus.rsp_ready[grant_q]) begin
                    last_d  = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= LAST_RST;
            last_q  <= LAST_RST;
            opa_q   <= '0;
            opb_q   <= '0;
            op_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            op_q    <= op_d;
            res_q   <= res_d;
        end
    end

    assign bus.rsp_data = res_q;
    assign fpu_opA      = opa_q;
    assign fpu_opB      = opb_q;
    assign fpu_op       = op_q;
    assign busy         = (state_q != IDLE);
    assign grant_id     = grant_q;
endmodule

// File: tb/tb_fpu_scheduler.sv
// tb_fpu_scheduler: directed, table-driven bench for fpu_scheduler with a
// behavioural FPU whose output is only valid from the expected sample cycle.
module tb_fpu_scheduler;
    localparam int NR = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fpu_opA, fpu_opB, fpu_out;
    logic [1:0]  fpu_op;
    logic        fpu_start, busy;
    logic [1:0]  grant_id;

    fpu_scheduler_if #(.NUM_REQ(NR)) bus ();

    fpu_scheduler #(.NUM_REQ(NR), .ADDSUB_LAT(2), .MULDIV_LAT(64)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .fpu_opA(fpu_opA), .fpu_opB(fpu_opB), .fpu_op(fpu_op),
        .fpu_start(fpu_start), .fpu_out(fpu_out),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    // ---------------- FPU model (normal numbers, truncating) ----------------
    function automatic real s2r(input logic [31:0] s);
        logic [10:0] e;
        logic [63:0] d;
        e = {3'b000, s[30:23]} + 11'd896;
        d = (s[30:23] == 8'd0) ? {s[31], 63'd0} : {s[31], e, s[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2s(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return (d[62:52] == 11'd0) ? {d[63], 31'd0} : {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fpu_calc(input logic [31:0] a, input logic [31:0] b,
                                             input logic [1:0] op);
        case (op)
            2'd0:    return r2s(s2r(a) + s2r(b));
            2'd1:    return r2s(s2r(a) - s2r(b));
            2'd2:    return r2s(s2r(a) * s2r(b));
            default: return r2s(s2r(a) / s2r(b));
        endcase
    endfunction

    int unsigned since   = 0;
    logic        started = 1'b0;
    logic [31:0] fres    = 32'd0;

    always @(posedge clk) begin
        if (fpu_start) begin
            since   <= 0;
            started <= 1'b1;
            fres    <= fpu_calc(fpu_opA, fpu_opB, fpu_op);
        end else if (since < 1000) begin
            since <= since + 1;
        end
    end

    // Garbage until the cycle the scheduler should sample (acceptance + LAT).
    assign fpu_out = (started && (int'(since) + 2 >= (fpu_op[1] ? 64 : 2))) ? fres : 32'hDEADBEEF;

    // ---------------- checking helpers ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int oh2i(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v == NR'(1 << i)) return i;
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},      64'(busy), 64'd0);
        chk({tag, "_start"},     64'(fpu_start), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
        chk({tag, "_rsp_data"},  64'(bus.rsp_data), 64'd0);
        chk({tag, "_fpu_ops"},   {fpu_opA, fpu_opB[29:0], fpu_op}, 64'd0);
        chk({tag, "_grant_id"},  64'(grant_id), 64'd3);
    endtask

    // Collect n responses (rsp_ready held high), return grant order.
    task automatic collect(input int n, output int order[8], output int bad_data);
        int got;
        logic [31:0] exp_res [NR];
        exp_res = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
        got = 0;
        bad_data = 0;
        for (int i = 0; i < 8; i++) order[i] = -1;
        for (int c = 0; c < 1000 && got < n; c++) begin
            @(negedge clk);
            #1;
            if (bus.rsp_valid != '0) begin
                order[got] = oh2i(bus.rsp_valid);
                if (order[got] < 0 || bus.rsp_data !== exp_res[order[got]]) bad_data++;
                got++;
                if (got == n) bus.req_valid = '0;
            end
        end
    endtask

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int cyc, starts, hold_bad, order[8], bad_data;
        logic [31:0] held;

        reset         = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        bus.req_opA   = '0;
        bus.req_opB   = '0;
        bus.req_op    = '0;

        vecs[0] = '{0, 32'h3F800000, 32'h40000000, 2'd0, 32'h40400000, 2};  // 1+2=3
        vecs[1] = '{1, 32'h40A00000, 32'h40400000, 2'd1, 32'h40000000, 2};  // 5-3=2
        vecs[2] = '{2, 32'h40000000, 32'h40400000, 2'd2, 32'h40C00000, 64}; // 2*3=6
        vecs[3] = '{2, 32'h40C00000, 32'h40000000, 2'd3, 32'h40400000, 64}; // 6/2=3
        vecs[4] = '{3, 32'hBF800000, 32'h3F000000, 2'd0, 32'hBF000000, 2};  // -1+0.5

        do_reset();
        chk_reset_outputs("reset");

        // ---- table-driven single operations ----
        foreach (vecs[k]) begin
            @(negedge clk);
            bus.req_opA[vecs[k].idx] = vecs[k].a;
            bus.req_opB[vecs[k].idx] = vecs[k].b;
            bus.req_op[vecs[k].idx]  = vecs[k].op;
            bus.req_valid            = NR'(1 << vecs[k].idx);
            #1;
            chk($sformatf("v%0d_req_ready", k), 64'(bus.req_ready), 64'(1 << vecs[k].idx));
            @(negedge clk);
            // Other requesters stay valid while this op is in flight.
            bus.req_valid = ~NR'(1 << vecs[k].idx);
            #1;
            cyc = 1;
            starts = 0;
            hold_bad = 0;
            while (bus.rsp_valid == '0 && cyc < 200) begin
                if (fpu_start) begin
                    starts++;
                    if (cyc != 1) hold_bad++;
                end
                if (!busy || bus.req_ready != '0) hold_bad++;
                @(negedge clk);
                #1;
                cyc++;
            end
            chk($sformatf("v%0d_latency", k), 64'(cyc), 64'(vecs[k].lat + 1));
            chk($sformatf("v%0d_start_once", k), 64'(starts), 64'd1);
            chk($sformatf("v%0d_busy_noready", k), 64'(hold_bad), 64'd0);
            chk($sformatf("v%0d_rsp_valid", k), 64'(bus.rsp_valid), 64'(1 << vecs[k].idx));
            chk($sformatf("v%0d_rsp_data", k), 64'(bus.rsp_data), 64'(vecs[k].exp));
            chk($sformatf("v%0d_grant_id", k), 64'(grant_id), 64'(vecs[k].idx));
            bus.req_valid = '0;
            bus.rsp_ready = NR'(1 << vecs[k].idx);
            @(negedge clk);
            #1;
            bus.rsp_ready = '0;
            chk($sformatf("v%0d_idle", k), 64'(busy), 64'd0);
        end

        // ---- all four valid from reset, rsp_ready high ----
        do_reset();
        bus.req_opA = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
        bus.req_opB = {4{32'h3F800000}};
        bus.req_op  = '0;
        bus.rsp_ready = '1;
        bus.req_valid = '1;
        collect(5, order, bad_data);
        chk("rr4_order", {32'(order[0]), 8'(order[1]), 8'(order[2]), 8'(order[3]), 8'(order[4])},
            {32'd0, 8'd1, 8'd2, 8'd3, 8'd0});
        chk("rr4_data", 64'(bad_data), 64'd0);

        // ---- requesters 1 and 3 continuously valid ----
        do_reset();
        bus.rsp_ready = '1;
        bus.req_valid = 4'b1010;
        collect(4, order, bad_data);
        chk("rr13_order", {32'(order[0]), 8'(order[1]), 8'(order[2]), 8'(order[3]), 8'd0},
            {32'd1, 8'd3, 8'd1, 8'd3, 8'd0});
        chk("rr13_data", 64'(bad_data), 64'd0);

        // ---- backpressure on the response channel ----
        do_reset();
        bus.req_opA[1] = 32'h3F800000;
        bus.req_opB[1] = 32'h3F800000;
        bus.req_op[1]  = 2'd0;
        bus.req_valid  = 4'b0010;
        @(negedge clk);
        bus.req_valid = 4'b0100;  // competing request during the whole op
        #1;
        cyc = 0;
        while (bus.rsp_valid == '0 && cyc < 200) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        held = bus.rsp_data;
        chk("bp_first_data", 64'(held), 64'h40000000);
        hold_bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            if (bus.rsp_valid != 4'b0010 || bus.rsp_data != held || bus.req_ready != '0) hold_bad++;
        end
        chk("bp_hold", 64'(hold_bad), 64'd0);
        bus.rsp_ready = 4'b1101;  // wrong bits are ignored
        @(negedge clk);
        #1;
        chk("bp_ignore_other_ready", 64'(bus.rsp_valid), 64'b0010);
        bus.rsp_ready = 4'b0010;
        @(negedge clk);
        #1;
        bus.rsp_ready = '0;
        chk("bp_idle", 64'(busy), 64'd0);
        chk("bp_next_grant", 64'(bus.req_ready), 64'b0100);
        bus.req_valid = '0;

        // ---- reset in the middle of a mul ----
        do_reset();
        bus.req_opA[1] = 32'h40000000;
        bus.req_opB[1] = 32'h40400000;
        bus.req_op[1]  = 2'd2;
        bus.req_valid  = 4'b0010;
        @(negedge clk);
        bus.req_valid = '0;
        repeat (10) @(negedge clk);
        #1;
        chk("mid_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        hold_bad = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            #1;
            if (bus.rsp_valid != '0 || busy) hold_bad++;
        end
        chk("midreset_no_rsp", 64'(hold_bad), 64'd0);
        bus.req_opA[0] = 32'h3F800000;
        bus.req_opB[0] = 32'h40000000;
        bus.req_op[0]  = 2'd0;
        bus.req_valid  = 4'b0101;
        #1;
        chk("midreset_first_grant", 64'(bus.req_ready), 64'b0001);
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        chk("midreset_grant_id", 64'(grant_id), 64'd0);
        chk("midreset_start", 64'(fpu_start), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
